// File: rtl/encoder_pkg.sv
// Shared definitions for the time-multiplexed quadrature decoder.
package encoder_pkg;

  // Quadrature AB states, encoded as {A, B}.
  localparam logic [1:0] S00 = 2'b00;
  localparam logic [1:0] S01 = 2'b01;
  localparam logic [1:0] S11 = 2'b11;
  localparam logic [1:0] S10 = 2'b10;

  // Outcome of comparing one channel's stored AB with its current AB.
  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_INC  = 2'd1,
    STEP_DEC  = 2'd2,
    STEP_ERR  = 2'd3
  } step_t;

  // Channel-index width; never narrower than one bit.
  function automatic int ch_w(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/quad_step.sv
// Combinational quadrature step decode: one detent is counted on the
// return to 00, forward from 10 and backward from 01.
module quad_step
  import encoder_pkg::*;
(
  input  logic [1:0] prev,
  input  logic [1:0] curr,
  output step_t      step
);

  // Classify the transition prev -> curr.
  always_comb begin
    step = STEP_NONE;
    if ((prev ^ curr) == 2'b11) begin
      step = STEP_ERR;
    end else if (prev == S10 && curr == S00) begin
      step = STEP_INC;
    end else if (prev == S01 && curr == S00) begin
      step = STEP_DEC;
    end
  end

endmodule

// File: rtl/encoder_scheduler.sv
// Round-robin quadrature decoder shared by CHANNELS rotary encoders.
// One channel is decoded per cycle; values, AB history and error flags
// live in a small per-channel register file with a host load port.
module encoder_scheduler
  import encoder_pkg::*;
#(
  parameter  int CHANNELS = 3,
  parameter  int WIDTH    = 8,
  localparam int CH_W     = ch_w(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       a,
  input  logic [CHANNELS-1:0]       b,
  input  logic                      load_valid,
  input  logic [CH_W-1:0]           load_ch,
  input  logic [WIDTH-1:0]          load_value,
  output logic [CHANNELS*WIDTH-1:0] value,
  output logic                      upd_valid,
  output logic [CH_W-1:0]           upd_ch,
  output logic [CHANNELS-1:0]       err,
  input  logic                      err_clr
);

  localparam logic [CH_W-1:0] CH_LAST = CH_W'(CHANNELS - 1);
  localparam logic [CH_W:0]   CH_LIM  = (CH_W + 1)'(CHANNELS);

  // Modulo-2^WIDTH count step.
  function automatic logic [WIDTH-1:0] count_step(input logic [WIDTH-1:0] v,
                                                  input logic up);
    return up ? (v + WIDTH'(1)) : (v - WIDTH'(1));
  endfunction

  logic [CHANNELS-1:0] a_sync_p0, a_sync_p1;
  logic [CHANNELS-1:0] b_sync_p0, b_sync_p1;
  logic [CH_W-1:0]     slot;
  logic [1:0]          sync_fill;
  logic [1:0]          hist [CHANNELS];
  logic [CHANNELS-1:0] primed;
  logic [WIDTH-1:0]    vals [CHANNELS];
  logic [1:0]          prev;
  logic [1:0]          curr;
  step_t               step;
  logic                decode_en;
  logic                load_ok;
  logic                load_hit;

  // Two-flop synchronizers for the asynchronous encoder pins.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_sync_p0 <= '0;
      a_sync_p1 <= '0;
      b_sync_p0 <= '0;
      b_sync_p1 <= '0;
    end else begin
      a_sync_p0 <= a;
      a_sync_p1 <= a_sync_p0;
      b_sync_p0 <= b;
      b_sync_p1 <= b_sync_p0;
    end
  end

  // Slot counter, plus a fill count so no channel primes its history from
  // the reset contents of the synchronizer instead of the real pins.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot      <= '0;
      sync_fill <= 2'd0;
    end else begin
      slot <= (slot == CH_LAST) ? '0 : slot + CH_W'(1);
      if (sync_fill != 2'd2) begin
        sync_fill <= sync_fill + 2'd1;
      end
    end
  end

  // Select the serviced channel's history and pins; qualify the host load.
  always_comb begin
    curr      = {a_sync_p1[slot], b_sync_p1[slot]};
    prev      = hist[slot];
    decode_en = (sync_fill == 2'd2);
    load_ok   = load_valid && ({1'b0, load_ch} < CH_LIM);
    load_hit  = load_ok && (load_ch == slot);
  end

  quad_step u_quad_step (
    .prev (prev),
    .curr (curr),
    .step (step)
  );

  // Register file update: decode of the current slot, then host load
  // (which overrides a count on the same channel), with sticky errors.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < CHANNELS; k++) begin
        hist[k] <= S00;
        vals[k] <= '0;
      end
      primed    <= '0;
      err       <= '0;
      upd_valid <= 1'b0;
      upd_ch    <= '0;
    end else begin
      upd_valid <= 1'b0;
      if (err_clr) begin
        err <= '0;
      end
      if (decode_en) begin
        hist[slot] <= curr;
        if (!primed[slot]) begin
          primed[slot] <= 1'b1;
        end else begin
          case (step)
            STEP_INC, STEP_DEC: begin
              if (!load_hit) begin
                vals[slot] <= count_step(vals[slot], step == STEP_INC);
                upd_valid  <= 1'b1;
                upd_ch     <= slot;
              end
            end
            STEP_ERR: err[slot] <= 1'b1;
            default: ;
          endcase
        end
      end
      if (load_ok) begin
        vals[load_ch] <= load_value;
      end
    end
  end

  // Flatten the register file onto the value bus.
  for (genvar k = 0; k < CHANNELS; k++) begin : g_value
    assign value[k*WIDTH +: WIDTH] = vals[k];
  end

endmodule

// File: tb/tb_encoder_scheduler.sv
// Directed bench for encoder_scheduler (3 channels, 8-bit values).
module tb_encoder_scheduler;

  logic        clk;
  logic        reset;
  logic [2:0]  a_pin;
  logic [2:0]  b_pin;
  logic        load_valid;
  logic [1:0]  load_ch;
  logic [7:0]  load_value;
  logic [23:0] value;
  logic        upd_valid;
  logic [1:0]  upd_ch;
  logic [2:0]  err;
  logic        err_clr;

  int checks = 0;
  int errors = 0;
  int mslot  = 0;

  encoder_scheduler #(.CHANNELS(3), .WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .a          (a_pin),
    .b          (b_pin),
    .load_valid (load_valid),
    .load_ch    (load_ch),
    .load_value (load_value),
    .value      (value),
    .upd_valid  (upd_valid),
    .upd_ch     (upd_ch),
    .err        (err),
    .err_clr    (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference slot timing: 0 after reset, then 0,1,2,0,...
  always @(posedge clk) begin
    if (reset) mslot <= 0;
    else       mslot <= (mslot == 2) ? 0 : mslot + 1;
  end

  typedef struct {
    bit          is_load;
    logic [1:0]  ch;
    logic [1:0]  ab;
    logic [7:0]  ld;
    logic [23:0] exp_val;
    logic [2:0]  exp_err;
    int          exp_pulses;
    string       name;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic add_pin(input logic [1:0] ch, input logic [1:0] ab, input logic [23:0] v,
                         input logic [2:0] e, input int p, input string name);
    vec_t r;
    r.is_load = 1'b0; r.ch = ch; r.ab = ab; r.ld = 8'h00;
    r.exp_val = v; r.exp_err = e; r.exp_pulses = p; r.name = name;
    tbl.push_back(r);
  endtask

  task automatic add_load(input logic [1:0] ch, input logic [7:0] ld, input logic [23:0] v,
                          input logic [2:0] e, input string name);
    vec_t r;
    r.is_load = 1'b1; r.ch = ch; r.ab = 2'b00; r.ld = ld;
    r.exp_val = v; r.exp_err = e; r.exp_pulses = 0; r.name = name;
    tbl.push_back(r);
  endtask

  // Apply one record, let it settle for 8 cycles, count update pulses.
  task automatic run_vec(input vec_t v);
    int pulses = 0;
    if (v.is_load) begin
      load_valid = 1'b1; load_ch = v.ch; load_value = v.ld;
    end else begin
      a_pin[v.ch] = v.ab[1]; b_pin[v.ch] = v.ab[0];
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      load_valid = 1'b0;
      if (upd_valid) begin
        pulses++;
        chk({v.name, "_upd_ch"}, 32'(upd_ch), 32'(v.ch));
      end
    end
    chk({v.name, "_value"}, 32'(value), 32'(v.exp_val));
    chk({v.name, "_err"}, 32'(err), 32'(v.exp_err));
    chk({v.name, "_pulses"}, 32'(pulses), 32'(v.exp_pulses));
  endtask

  task automatic run_all();
    foreach (tbl[i]) run_vec(tbl[i]);
    tbl.delete();
  endtask

  task automatic wait_slot(input int s);
    int n = 0;
    while (mslot != s && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (mslot != s) begin
      checks++;
      errors++;
      $display("FAIL wait_slot actual=%0d expected=%0d", mslot, s);
    end
  endtask

  task automatic count_pulses(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      load_valid = 1'b0;
      if (upd_valid) pulses++;
    end
  endtask

  initial begin
    int p;
    reset = 1'b1; a_pin = 3'b111; b_pin = 3'b111;
    load_valid = 1'b0; load_ch = 2'd0; load_value = 8'h00; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_value", 32'(value), 32'h0);
    chk("rst_upd_valid", 32'(upd_valid), 32'h0);
    chk("rst_upd_ch", 32'(upd_ch), 32'h0);
    chk("rst_err", 32'(err), 32'h0);

    // Prime every channel at AB=11.
    reset = 1'b0;
    count_pulses(10, p);
    chk("prime11_value", 32'(value), 32'h0);
    chk("prime11_err", 32'(err), 32'h0);
    chk("prime11_pulses", 32'(p), 32'h0);

    // Restart with all pins at 00 so detents begin from the rest state.
    reset = 1'b1; a_pin = 3'b000; b_pin = 3'b000;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    for (int r = 1; r <= 3; r++) begin
      add_pin(1, 2'b01, {8'h00, 8'(r - 1), 8'h00}, 3'b000, 0, "ch1_fwd_01");
      add_pin(1, 2'b11, {8'h00, 8'(r - 1), 8'h00}, 3'b000, 0, "ch1_fwd_11");
      add_pin(1, 2'b10, {8'h00, 8'(r - 1), 8'h00}, 3'b000, 0, "ch1_fwd_10");
      add_pin(1, 2'b00, {8'h00, 8'(r), 8'h00}, 3'b000, 1, "ch1_fwd_00");
    end
    add_pin(0, 2'b10, 24'h000300, 3'b000, 0, "ch0_rev_10");
    add_pin(0, 2'b11, 24'h000300, 3'b000, 0, "ch0_rev_11");
    add_pin(0, 2'b01, 24'h000300, 3'b000, 0, "ch0_rev_01");
    add_pin(0, 2'b00, 24'h0003FF, 3'b000, 1, "ch0_rev_00");
    add_load(2, 8'hFE, 24'hFE03FF, 3'b000, "ch2_load");
    add_load(3, 8'h77, 24'hFE03FF, 3'b000, "bad_ch_load");
    add_pin(2, 2'b01, 24'hFE03FF, 3'b000, 0, "ch2_fwd_01");
    add_pin(2, 2'b11, 24'hFE03FF, 3'b000, 0, "ch2_fwd_11");
    add_pin(2, 2'b10, 24'hFE03FF, 3'b000, 0, "ch2_fwd_10");
    add_pin(2, 2'b00, 24'hFF03FF, 3'b000, 1, "ch2_fwd_00");
    add_pin(2, 2'b01, 24'hFF03FF, 3'b000, 0, "ch2_wrap_01");
    add_pin(2, 2'b11, 24'hFF03FF, 3'b000, 0, "ch2_wrap_11");
    add_pin(2, 2'b10, 24'hFF03FF, 3'b000, 0, "ch2_wrap_10");
    add_pin(2, 2'b00, 24'h0003FF, 3'b000, 1, "ch2_wrap_00");
    add_pin(2, 2'b11, 24'h0003FF, 3'b100, 0, "ch2_jump");
    run_all();

    // Sticky until cleared.
    repeat (4) @(negedge clk);
    chk("err_sticky", 32'(err), 32'h4);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    @(negedge clk);
    chk("err_clear", 32'(err), 32'h0);

    // err_clr in the very cycle ch2 decodes an illegal 11->00 jump.
    wait_slot(0);
    a_pin[2] = 1'b0; b_pin[2] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_set_wins", 32'(err), 32'h4);
    repeat (6) @(negedge clk);
    chk("err_set_hold", 32'(err), 32'h4);
    chk("err_value", 32'(value), 32'h0003FF);

    add_pin(0, 2'b01, 24'h0003FF, 3'b100, 0, "ch0_pre_01");
    add_pin(0, 2'b11, 24'h0003FF, 3'b100, 0, "ch0_pre_11");
    add_pin(0, 2'b10, 24'h0003FF, 3'b100, 0, "ch0_pre_10");
    run_all();

    // Host load lands in the same cycle as ch0's counting 10->00 slot.
    wait_slot(1);
    a_pin[0] = 1'b0; b_pin[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    load_valid = 1'b1; load_ch = 2'd0; load_value = 8'h40;
    count_pulses(8, p);
    chk("collide_pulses", 32'(p), 32'h0);
    chk("collide_value", 32'(value), 32'h000340);

    add_pin(0, 2'b01, 24'h000340, 3'b100, 0, "ch0_post_01");
    add_pin(0, 2'b11, 24'h000340, 3'b100, 0, "ch0_post_11");
    add_pin(0, 2'b10, 24'h000340, 3'b100, 0, "ch0_post_10");
    add_pin(0, 2'b00, 24'h000341, 3'b100, 1, "ch0_post_00");
    run_all();

    // Reset one cycle after a ch1 pin edge.
    a_pin[1] = 1'b0; b_pin[1] = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_value", 32'(value), 32'h0);
    chk("midrst_err", 32'(err), 32'h0);
    chk("midrst_upd", 32'(upd_valid), 32'h0);
    reset = 1'b0;
    count_pulses(10, p);
    chk("postrst_pulses", 32'(p), 32'h0);
    chk("postrst_value", 32'(value), 32'h0);
    chk("postrst_err", 32'(err), 32'h0);

    add_pin(1, 2'b11, 24'h000000, 3'b000, 0, "ch1_rst_11");
    add_pin(1, 2'b10, 24'h000000, 3'b000, 0, "ch1_rst_10");
    add_pin(1, 2'b00, 24'h000100, 3'b000, 1, "ch1_rst_00");
    run_all();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
